multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
Sequencing controller for the shared iterative multiply/divide unit in the execute stage. Accepts MULT/DIV requests from the pipeline, latches operands and destination tag, and launches the unit with a one-cycle start pulse. Holds the pipeline stalled until the unit reports ready, then presents the result to writeback with a valid/ready handshake. Also handles divide-by-zero, timeout and flush.

Parameters:
TIMEOUT, 40, max BUSY cycles waiting for unit_ready before forcing an exception completion
TAG_W, 5, destination register tag width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
ctrl_MULT  in  1  multiply request; sampled only in IDLE
ctrl_DIV  in  1  divide request; sampled only in IDLE
operandA  in  32  dividend / multiplicand
operandB  in  32  divisor / multiplier
dest_tag  in  TAG_W  destination register of the request
flush  in  1  abort current operation (branch mispredict)
unit_start  out  1  one-cycle launch pulse to the unit
unit_sel  out  1  0 = multiply, 1 = divide; stable from launch to completion
unit_A  out  32  latched operandA
unit_B  out  32  latched operandB
unit_ready  in  1  unit completion strobe
unit_result  in  32  unit result
unit_exception  in  1  unit overflow / div-by-zero flag
stall  out  1  hold upstream pipeline
result_valid  out  1  result available to writeback
result  out  32  captured result
result_exception  out  1  exception flag for the result
result_tag  out  TAG_W  destination tag for the result
wb_ready  in  1  writeback accepts result this cycle

Behaviour:
- States: IDLE, START, BUSY, DONE.
- Reset: state IDLE. unit_start, stall and result_valid = 0. result, result_exception, result_tag, unit_A, unit_B and unit_sel = 0. Cycle counter = 0.
- IDLE, request seen (ctrl_MULT | ctrl_DIV):
  - Latch operandA, operandB and dest_tag.
  - unit_sel = ctrl_DIV (DIV has priority if both are high).
  - Go to START. The decision to launch follows the next rule.
- IDLE, DIV with operandB == 0:
  - Unit is not launched.
  - Go directly to DONE with result = 0 and result_exception = 1.
- START: unit_start = 1 for exactly this cycle. unit_ready is ignored. Go to BUSY and clear the counter.
- BUSY:
  - Counter increments each cycle.
  - On unit_ready: capture unit_result and unit_exception, then go to DONE.
  - If the counter reaches TIMEOUT without ready: result = 0, result_exception = 1, go to DONE.
  - If ready arrives in the same cycle the timeout is reached, ready wins.
- DONE:
  - result_valid = 1. result, result_tag and result_exception are held stable.
  - On wb_ready: go to IDLE the next cycle.
  - A new request is not accepted in the same cycle as the wb_ready handshake.
- stall (combinational) = (IDLE & request) | START | BUSY | (DONE & ~wb_ready).
- Requests arriving while not in IDLE are ignored; the pipeline is stalled, so they are re-presented.
- flush: in any state, go to IDLE next cycle. result_valid and unit_start drop next cycle, and stall deasserts next cycle. A unit_ready arriving after the flush is discarded.
- Priority: reset > flush > all other transitions.
- Latency, unit of N cycles: request at cycle 0, unit_start at cycle 1, result_valid at the cycle after unit_ready.

Optional Feature:
MULTDIV_FASTPATH_EN
- Defined: in IDLE, MULT with operandB == 0 or operandA == 0 completes directly to DONE with result 0. MULT with operandB == 1 completes with result = operandA. DIV with operandB == 1 completes with result = operandA. In all these cases the unit is not launched and result_exception = 0.
- Undefined: these cases launch the unit normally. Div-by-zero handling is unaffected either way.

Test Plan:
- DIV A=100, B=7; unit_ready 33 cycles after start, unit_result = 14 -> unit_start 1 cycle at cycle 1, unit_sel = 1, stall high throughout, result_valid with result = 14, tag preserved, exception = 0.
- DIV A=5, B=0 -> no unit_start; DONE next cycle with result = 0, result_exception = 1.
- MULT A=3, B=4, unit_ready after 10 cycles; wb_ready low for 3 cycles -> result = 12 held stable, stall high until the wb_ready cycle, then IDLE.
- unit_ready never asserted -> after TIMEOUT = 40 BUSY cycles, result_valid with result = 0, exception = 1.
- flush in BUSY cycle 5, then late unit_ready -> IDLE next cycle, no result_valid, stall low.
- ctrl_MULT and ctrl_DIV both high with A=9, B=3 -> unit_sel = 1. With MULTDIV_FASTPATH_EN, MULT A=9, B=1 -> result 9 with no unit_start.

Source files
------------

// File: rtl/multdiv_ctrl.sv
`timescale 1ns/1ps
// multdiv_ctrl
// Sequencing controller for the shared iterative multiply/divide unit in the
// execute stage. A MULT/DIV request seen in IDLE latches the operands and the
// destination tag. The unit is launched with a one-cycle start pulse, and the
// pipeline is stalled until the unit reports ready. The captured result is
// then offered to writeback with a valid/ready handshake. The controller also
// handles divide-by-zero (no launch), a BUSY timeout and flush.
//
// Optional build macro: MULTDIV_FASTPATH_EN
//   When defined, trivial operands complete straight from IDLE without
//   launching the unit:
//     MULT by zero           -> result 0
//     MULT by one            -> result operandA
//     DIV by one             -> result operandA
//   When undefined, these requests launch the unit like any other.
//   Divide-by-zero handling is the same in both builds.
module multdiv_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int TAG_W   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [31:0]      operandA,
    input  logic [31:0]      operandB,
    input  logic [TAG_W-1:0] dest_tag,
    input  logic             flush,
    output logic             unit_start,
    output logic             unit_sel,
    output logic [31:0]      unit_A,
    output logic [31:0]      unit_B,
    input  logic             unit_ready,
    input  logic [31:0]      unit_result,
    input  logic             unit_exception,
    output logic             stall,
    output logic             result_valid,
    output logic [31:0]      result,
    output logic             result_exception,
    output logic [TAG_W-1:0] result_tag,
    input  logic             wb_ready
);

    // Wide enough to hold TIMEOUT itself.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               sel_q, sel_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        result_q, result_d;
    logic               exc_q, exc_d;

    logic               req;
    logic               div_by_zero;
    logic               timeout_hit;
    logic               fast_hit;
    logic [31:0]        fast_value;

    assign req         = ctrl_MULT | ctrl_DIV;
    // DIV has priority over MULT, so a zero divisor matters whenever DIV is high.
    assign div_by_zero = ctrl_DIV && (operandB == 32'd0);
    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

`ifdef MULTDIV_FASTPATH_EN
    // Detect requests whose answer is known without running the unit.
    always_comb begin
        fast_hit   = 1'b0;
        fast_value = 32'd0;
        if (ctrl_DIV) begin
            if (operandB == 32'd1) begin
                fast_hit   = 1'b1;
                fast_value = operandA;
            end
        end else if (ctrl_MULT) begin
            if ((operandA == 32'd0) || (operandB == 32'd0)) begin
                fast_hit   = 1'b1;
                fast_value = 32'd0;
            end else if (operandB == 32'd1) begin
                fast_hit   = 1'b1;
                fast_value = operandA;
            end
        end
    end
`else
    assign fast_hit   = 1'b0;
    assign fast_value = 32'd0;
`endif

    // Next-state, datapath-capture and Moore-output logic of the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        tag_d        = tag_q;
        result_d     = result_q;
        exc_d        = exc_q;
        unit_start   = 1'b0;
        result_valid = 1'b0;
        stall        = 1'b0;

        case (state_q)
            IDLE:  stall = req;
            START: begin
                unit_start = 1'b1;
                stall      = 1'b1;
            end
            BUSY:  stall = 1'b1;
            DONE: begin
                result_valid = 1'b1;
                stall        = ~wb_ready;
            end
            default: ;
        endcase

        if (flush) begin
            // Abandon whatever is in flight. A ready that arrives later finds
            // the controller in IDLE, where the ready is ignored.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        a_d   = operandA;
                        b_d   = operandB;
                        tag_d = dest_tag;
                        sel_d = ctrl_DIV;
                        if (div_by_zero) begin
                            result_d = 32'd0;
                            exc_d    = 1'b1;
                            state_d  = DONE;
                        end else if (fast_hit) begin
                            result_d = fast_value;
                            exc_d    = 1'b0;
                            state_d  = DONE;
                        end else begin
                            state_d  = START;
                        end
                    end
                end
                START: begin
                    // unit_ready is ignored during the launch cycle.
                    cnt_d   = '0;
                    state_d = BUSY;
                end
                BUSY: begin
                    cnt_d = cnt_inc;
                    if (unit_ready) begin
                        // Ready wins over a timeout reached in the same cycle.
                        result_d = unit_result;
                        exc_d    = unit_exception;
                        state_d  = DONE;
                    end else if (timeout_hit) begin
                        result_d = 32'd0;
                        exc_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (wb_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and latched-operand/result registers, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sel_q    <= 1'b0;
            tag_q    <= '0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign unit_sel         = sel_q;
    assign unit_A           = a_q;
    assign unit_B           = b_q;
    assign result           = result_q;
    assign result_exception = exc_q;
    assign result_tag       = tag_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
`timescale 1ns/1ps
// Testbench for multdiv_ctrl: directed scenarios with literal expectations,
// followed by randomized traffic that is checked every cycle against a
// transaction-level reference model. Building with MULTDIV_FASTPATH_EN
// defined also selects the fast-path expectations.
module tb_multdiv_ctrl;
    localparam int TIMEOUT = 40;
    localparam int TAG_W   = 5;
`ifdef MULTDIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             ctrl_MULT = 1'b0;
    logic             ctrl_DIV = 1'b0;
    logic [31:0]      operandA = '0;
    logic [31:0]      operandB = '0;
    logic [TAG_W-1:0] dest_tag = '0;
    logic             flush = 1'b0;
    logic             unit_start;
    logic             unit_sel;
    logic [31:0]      unit_A;
    logic [31:0]      unit_B;
    logic             unit_ready = 1'b0;
    logic [31:0]      unit_result = '0;
    logic             unit_exception = 1'b0;
    logic             stall;
    logic             result_valid;
    logic [31:0]      result;
    logic             result_exception;
    logic [TAG_W-1:0] result_tag;
    logic             wb_ready = 1'b0;

    always #5 clock = ~clock;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .operandA(operandA), .operandB(operandB), .dest_tag(dest_tag), .flush(flush),
        .unit_start(unit_start), .unit_sel(unit_sel), .unit_A(unit_A), .unit_B(unit_B),
        .unit_ready(unit_ready), .unit_result(unit_result), .unit_exception(unit_exception),
        .stall(stall), .result_valid(result_valid), .result(result),
        .result_exception(result_exception), .result_tag(result_tag), .wb_ready(wb_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The answer for requests the controller settles itself, without the unit.
    function automatic bit fast_done(input bit is_div, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] v);
        v = '0;
        if (FAST && !is_div && (a == 0 || b == 0)) return 1'b1;
        if (FAST && b == 32'd1) begin
            v = a;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    bit               m_live = 1'b0;
    bit               m_launch = 1'b0;
    bit               m_wait = 1'b0;
    bit               m_offer = 1'b0;
    int               m_waited = 0;
    logic [31:0]      m_A = '0, m_B = '0, m_res = '0;
    logic             m_sel = 1'b0, m_exc = 1'b0;
    logic [TAG_W-1:0] m_tag = '0;

    always @(negedge clock) begin : model_chk
        bit          req;
        bit          in_op;
        bit          e_stall;
        logic [31:0] fv;
        req   = ctrl_MULT | ctrl_DIV;
        in_op = m_launch | m_wait | m_offer;
        if (m_live) begin
            e_stall = (!in_op && req) || m_launch || m_wait || (m_offer && !wb_ready);
            check1("m_unit_start", unit_start, m_launch);
            check1("m_result_valid", result_valid, m_offer);
            check1("m_stall", stall, e_stall);
            if (in_op) begin
                check1("m_unit_sel", unit_sel, m_sel);
                check32("m_unit_A", unit_A, m_A);
                check32("m_unit_B", unit_B, m_B);
            end
            if (m_offer) begin
                check32("m_result", result, m_res);
                check1("m_result_exc", result_exception, m_exc);
                check32("m_result_tag", 32'(result_tag), 32'(m_tag));
            end
        end
        // Advance the model with the inputs that the next rising edge samples.
        if (reset) begin
            m_live = 1'b1; m_launch = 1'b0; m_wait = 1'b0; m_offer = 1'b0;
            m_A = '0; m_B = '0; m_sel = 1'b0; m_tag = '0; m_res = '0; m_exc = 1'b0;
        end else if (!m_live) begin
            m_live = 1'b0;
        end else if (flush) begin
            m_launch = 1'b0; m_wait = 1'b0; m_offer = 1'b0;
        end else if (m_offer) begin
            if (wb_ready) m_offer = 1'b0;
        end else if (m_wait) begin
            m_waited++;
            if (unit_ready) begin
                m_res = unit_result; m_exc = unit_exception;
                m_wait = 1'b0; m_offer = 1'b1;
            end else if (m_waited == TIMEOUT) begin
                m_res = '0; m_exc = 1'b1;
                m_wait = 1'b0; m_offer = 1'b1;
            end
        end else if (m_launch) begin
            m_launch = 1'b0; m_wait = 1'b1; m_waited = 0;
        end else if (req) begin
            m_A = operandA; m_B = operandB; m_tag = dest_tag; m_sel = ctrl_DIV;
            if (ctrl_DIV && operandB == 0) begin
                m_res = '0; m_exc = 1'b1; m_offer = 1'b1;
            end else if (fast_done(ctrl_DIV, operandA, operandB, fv)) begin
                m_res = fv; m_exc = 1'b0; m_offer = 1'b1;
            end else begin
                m_launch = 1'b1;
            end
        end
    end

    // ---------------- unit model and per-cycle stimulus helpers ----------------
    int               u_lat = 1;        // latency for the next launch, -1 = never
    bit               u_exc_next = 1'b0;
    int               u_cnt = -1;
    logic [31:0]      u_res = '0;
    logic             u_exc = 1'b0;
    int               hold = 0;         // cycles after flush/reset with no new requests
    logic             o_start, o_valid, o_stall, o_exc, o_sel;
    logic [31:0]      o_res, o_A, o_B;
    logic [TAG_W-1:0] o_tag;

    task automatic unit_step();
        unit_ready     = 1'b0;
        unit_result    = $urandom;
        unit_exception = 1'b0;
        if (o_start === 1'b1) begin
            u_cnt = u_lat;
            u_res = o_sel ? ((o_B != 0) ? o_A / o_B : 32'hFFFF_FFFF) : o_A * o_B;
            u_exc = u_exc_next;
        end
        // After a flush/reset the stale answer arrives early, while no new work runs.
        if (hold > 0 && u_cnt > 2) u_cnt = 2;
        if (hold > 0) hold--;
        if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) begin
                unit_ready     = 1'b1;
                unit_result    = u_res;
                unit_exception = u_exc;
                u_cnt          = -1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        o_start = unit_start; o_valid = result_valid; o_stall = stall;
        o_res = result; o_exc = result_exception; o_tag = result_tag;
        o_sel = unit_sel; o_A = unit_A; o_B = unit_B;
        @(posedge clock);
        #1;
        unit_step();
    endtask

    task automatic request(input bit mul, input bit dv, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] t);
        ctrl_MULT = mul; ctrl_DIV = dv; operandA = a; operandB = b; dest_tag = t;
        tick();
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        operandA = $urandom; operandB = $urandom; dest_tag = TAG_W'($urandom);
    endtask

    task automatic run_until_valid(input string name, input int budget, output int n,
                                   output int starts, output bit stall_ok);
        bit got;
        n = 0; starts = 0; stall_ok = 1'b1; got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (o_valid === 1'b1) got = 1'b1;
            else begin
                n++;
                starts += int'(o_start === 1'b1);
                if (o_stall !== 1'b1) stall_ok = 1'b0;
            end
        end
        check1({name, "_reached_valid"}, got, 1'b1);
    endtask

    task automatic retire(input string name);
        wb_ready = 1'b1;
        tick();
        check1({name, "_hs_valid"}, o_valid, 1'b1);
        check1({name, "_hs_stall"}, o_stall, 1'b0);
        wb_ready = 1'b0;
        tick();
        check1({name, "_idle_valid"}, o_valid, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    initial begin : stim
        int n, starts, exp_starts;
        bit stall_ok;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check1("rst_unit_start", o_start, 1'b0);
        check1("rst_stall", o_stall, 1'b0);
        check1("rst_valid", o_valid, 1'b0);
        check32("rst_result", o_res, 32'd0);
        check1("rst_exc", o_exc, 1'b0);
        check32("rst_tag", 32'(o_tag), 32'd0);
        check1("rst_sel", o_sel, 1'b0);
        check32("rst_A", o_A, 32'd0);
        check32("rst_B", o_B, 32'd0);
        reset = 1'b0;
        tick();

        // DIV 100/7, unit ready 33 cycles after start with 14
        u_lat = 33; u_exc_next = 1'b0;
        request(1'b0, 1'b1, 32'd100, 32'd7, 5'd13);
        check1("d1_req_stall", o_stall, 1'b1);
        check1("d1_req_nostart", o_start, 1'b0);
        tick();
        check1("d1_start", o_start, 1'b1);
        check1("d1_sel", o_sel, 1'b1);
        check32("d1_A", o_A, 32'd100);
        check32("d1_B", o_B, 32'd7);
        run_until_valid("d1", 80, n, starts, stall_ok);
        check32("d1_busy_cycles", 32'(n), 32'd33);
        check32("d1_extra_starts", 32'(starts), 32'd0);
        check1("d1_stall_held", stall_ok, 1'b1);
        check32("d1_result", o_res, 32'd14);
        check1("d1_exc", o_exc, 1'b0);
        check32("d1_tag", 32'(o_tag), 32'd13);
        check1("d1_stall_wb_low", o_stall, 1'b1);
        retire("d1");

        // DIV by zero: no launch, DONE the next cycle
        request(1'b0, 1'b1, 32'd5, 32'd0, 5'd7);
        check1("d2_req_stall", o_stall, 1'b1);
        tick();
        check1("d2_nostart", o_start, 1'b0);
        check1("d2_valid", o_valid, 1'b1);
        check32("d2_result", o_res, 32'd0);
        check1("d2_exc", o_exc, 1'b1);
        check32("d2_tag", 32'(o_tag), 32'd7);
        retire("d2");

        // MULT 3*4 after 10 cycles, writeback back-pressure for 3 cycles
        u_lat = 10;
        request(1'b1, 1'b0, 32'd3, 32'd4, 5'd21);
        tick();
        check1("d3_start", o_start, 1'b1);
        check1("d3_sel", o_sel, 1'b0);
        run_until_valid("d3", 40, n, starts, stall_ok);
        check32("d3_busy_cycles", 32'(n), 32'd10);
        check32("d3_result", o_res, 32'd12);
        for (int i = 0; i < 2; i++) begin
            tick();
            check1("d3_hold_valid", o_valid, 1'b1);
            check1("d3_hold_stall", o_stall, 1'b1);
            check32("d3_hold_result", o_res, 32'd12);
            check32("d3_hold_tag", 32'(o_tag), 32'd21);
        end
        retire("d3");

        // No unit_ready at all: timeout after exactly TIMEOUT busy cycles
        u_lat = -1;
        request(1'b1, 1'b0, 32'd6, 32'd7, 5'd3);
        tick();
        run_until_valid("d4", 80, n, starts, stall_ok);
        check32("d4_busy_cycles", 32'(n), 32'd40);
        check32("d4_result", o_res, 32'd0);
        check1("d4_exc", o_exc, 1'b1);
        retire("d4");

        // Ready in the very cycle the timeout is reached: ready wins
        u_lat = 40; u_exc_next = 1'b1;
        request(1'b1, 1'b0, 32'd7, 32'd6, 5'd30);
        tick();
        run_until_valid("d4b", 80, n, starts, stall_ok);
        check32("d4b_busy_cycles", 32'(n), 32'd40);
        check32("d4b_result", o_res, 32'd42);
        check1("d4b_exc", o_exc, 1'b1);
        retire("d4b");
        u_exc_next = 1'b0;

        // Ready one cycle too late: timeout result stays, late ready ignored
        u_lat = 41;
        request(1'b1, 1'b0, 32'd7, 32'd6, 5'd31);
        tick();
        run_until_valid("d4c", 80, n, starts, stall_ok);
        check32("d4c_busy_cycles", 32'(n), 32'd40);
        tick();
        check32("d4c_result", o_res, 32'd0);
        check1("d4c_exc", o_exc, 1'b1);
        retire("d4c");

        // Flush in BUSY cycle 5, late unit_ready afterwards
        u_lat = 20;
        request(1'b1, 1'b0, 32'd2, 32'd2, 5'd1);
        tick();
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1; hold = 6;
        tick();
        check1("d5_flush_cycle_stall", o_stall, 1'b1);
        flush = 1'b0;
        tick();
        check1("d5_after_stall", o_stall, 1'b0);
        check1("d5_after_valid", o_valid, 1'b0);
        check1("d5_after_start", o_start, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check1("d5_quiet_valid", o_valid, 1'b0);
        end

        // MULT and DIV together: DIV wins
        u_lat = 3;
        request(1'b1, 1'b1, 32'd9, 32'd3, 5'd9);
        tick();
        check1("d6_start", o_start, 1'b1);
        check1("d6_sel", o_sel, 1'b1);
        run_until_valid("d6", 20, n, starts, stall_ok);
        check32("d6_result", o_res, 32'd3);
        retire("d6");

        // unit_ready during the launch cycle is ignored
        u_lat = 5;
        request(1'b1, 1'b0, 32'd3, 32'd5, 5'd11);
        unit_ready = 1'b1; unit_result = 32'hDEAD_BEEF;
        tick();
        check1("d8_start", o_start, 1'b1);
        run_until_valid("d8", 20, n, starts, stall_ok);
        check32("d8_busy_cycles", 32'(n), 32'd5);
        check32("d8_result", o_res, 32'd15);
        retire("d8");

        // MULT 9*1: fast path skips the unit when enabled
        u_lat = 2;
        exp_starts = FAST ? 0 : 1;
        request(1'b1, 1'b0, 32'd9, 32'd1, 5'd4);
        run_until_valid("d7", 20, n, starts, stall_ok);
        check32("d7_starts", 32'(starts), 32'(exp_starts));
        check32("d7_result", o_res, 32'd9);
        check1("d7_exc", o_exc, 1'b0);
        retire("d7");

        // Randomized traffic, checked by the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 599) == 0);
            flush = !reset && ($urandom_range(0, 49) == 0);
            if (reset || flush) hold = 6;
            wb_ready = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 19))
                0:       u_lat = -1;
                1:       u_lat = 39 + $urandom_range(0, 2);
                default: u_lat = $urandom_range(1, 12);
            endcase
            u_exc_next = ($urandom_range(0, 7) == 0);
            if (hold == 0 && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 3))
                    0, 3: begin ctrl_MULT = 1'b1; ctrl_DIV = 1'b0; end
                    1:    begin ctrl_MULT = 1'b0; ctrl_DIV = 1'b1; end
                    default: begin ctrl_MULT = 1'b1; ctrl_DIV = 1'b1; end
                endcase
                operandA = pick_operand();
                operandB = pick_operand();
                dest_tag = TAG_W'($urandom);
            end else begin
                ctrl_MULT = 1'b0;
                ctrl_DIV  = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
